// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction-memory port, control inputs, IF/ID outputs.
interface fetch_unit_if #(
  parameter int ADDR_W = 5
);
  logic              Stall;
  logic              BranchTaken;
  logic [31:0]       BranchTarget;
  logic [31:0]       Instruction;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       IfId_Instruction;
  logic [31:0]       IfId_PC;
  logic              IfId_Valid;
  logic              Halted;
  logic              Misaligned;

  modport master (
    input  Stall, BranchTaken, BranchTarget, Instruction,
    output Address, IfId_Instruction, IfId_PC, IfId_Valid, Halted, Misaligned
  );

  modport slave (
    output Stall, BranchTaken, BranchTarget, Instruction,
    input  Address, IfId_Instruction, IfId_PC, IfId_Valid, Halted, Misaligned
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with stall, branch bubble and EBREAK halt.
// Optional misaligned-branch trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);
  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_q;
  logic        ifid_valid_q;
  logic        halted_q;
  logic        trap_lock;
  logic [31:0] br_pc;

  assign br_pc = {bus.BranchTarget[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;
  assign trap_lock      = misaligned_q;
  assign bus.Misaligned = misaligned_q;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^bus.BranchTarget[1:0];
  assign trap_lock      = 1'b0;
  assign bus.Misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSN;
      ifid_pc_q    <= 32'h0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: state_q <= RUN;
        RUN, HALT: begin
          // A trap halt ignores branches; only reset leaves it.
          if (state_q == HALT && trap_lock) begin
            ifid_valid_q <= ifid_valid_q & bus.Stall;
          end else if (bus.BranchTaken) begin
            ifid_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.BranchTarget[1:0] != 2'b00) begin
              misaligned_q <= 1'b1;
              halted_q     <= 1'b1;
              state_q      <= HALT;
            end else
`endif
            begin
              pc_q     <= br_pc;
              halted_q <= 1'b0;
              state_q  <= RUN;
            end
          end else if (!bus.Stall) begin
            if (state_q == HALT) begin
              ifid_valid_q <= 1'b0;
            end else begin
              ifid_instr_q <= bus.Instruction;
              ifid_pc_q    <= pc_q;
              ifid_valid_q <= 1'b1;
              // EBREAK is delivered but the PC stops on it.
              if (bus.Instruction == EBREAK_INSN) begin
                halted_q <= 1'b1;
                state_q  <= HALT;
              end else begin
                pc_q <= pc_q + 32'd4;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Address          = pc_q[ADDR_W+1:2];
  assign bus.IfId_Instruction = ifid_instr_q;
  assign bus.IfId_PC          = ifid_pc_q;
  assign bus.IfId_Valid       = ifid_valid_q;
  assign bus.Halted           = halted_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. Holds the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction plus its PC into the IF/ID pipeline register consumed by the decoder. Supports hazard stalls, branch redirect with bubble insertion, and halt-on-EBREAK.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: byte PC loaded at reset.
- `ADDR_W`, default 5: instruction-memory word-address width (32 words).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Stall`  in  1  hazard hold; freezes PC and the IF/ID register.
- `BranchTaken`  in  1  one-cycle redirect request from the execute stage.
- `BranchTarget`  in  32  byte target PC, valid with `BranchTaken`.
- `Instruction`  in  32  instruction-memory read data for `Address`, same cycle.
- `Address`  out  ADDR_W  word address = `PC[ADDR_W+1:2]`, combinational from the PC register.
- `IfId_Instruction`  out  32  registered instruction.
- `IfId_PC`  out  32  registered byte PC of `IfId_Instruction`.
- `IfId_Valid`  out  1  IF/ID register holds a real instruction.
- `Halted`  out  1  fetch stopped on EBREAK.
- `Misaligned`  out  1  sticky misaligned-target flag (only with `FETCH_MISALIGN_TRAP_EN`; tied 0 otherwise).

## Operation

- Internal 32-bit `PC`. The 2-bit state FSM has states IDLE, RUN, HALT.
- Reset (async, `rst_n`=0): PC=`RESET_PC`, state=IDLE, `IfId_Instruction`=32'h0000_0013 (NOP), `IfId_PC`=0, `IfId_Valid`=0, `Halted`=0, `Misaligned`=0.
- IDLE: one cycle after reset release; no capture, PC held; goes to RUN unconditionally. The memory read path settles during this cycle.
- RUN, priority per cycle (highest first):
  1. `BranchTaken`: PC←`BranchTarget`; `IfId_Valid`←0 (the wrong-path instruction is discarded). Applies even when `Stall`=1.
  2. `Stall`: PC, all IfId_* outputs, and state hold.
  3. Otherwise: IfId_Instruction←`Instruction`, IfId_PC←PC, IfId_Valid←1, PC←PC+4.
- EBREAK (32'h0010_0073) captured under rule 3 → state HALT and `Halted`=1 on the same edge. PC is not incremented. The EBREAK itself is delivered with `IfId_Valid`=1.
- HALT: PC frozen; on the next unstalled edge `IfId_Valid`←0 and then stays 0. `BranchTaken` in HALT (an older branch cancels the halt) → rule 1 applies, `Halted`←0, state RUN. `Stall` in HALT holds the IF/ID register.
- PC arithmetic: 32-bit, modulo 2^32. `Address` uses only bits [ADDR_W+1:2], so the fetch address wraps every 4·2^ADDR_W bytes (PC 0x7C → 0x80 gives `Address` 31 → 0). `IfId_PC` carries the full unwrapped PC.
- `BranchTarget[1:0]` is ignored unless the macro is defined: the low bits are cleared on load.

## Timing

- `Address` is valid combinationally from the PC register. The instruction is captured at the next rising edge. Fetch-to-IF/ID latency is 1 cycle. Throughput is 1 instruction/cycle.
- A branch costs 1 bubble: the edge that samples `BranchTaken` writes `IfId_Valid`=0, and the next edge captures the instruction at the target.
- `Stall` and `BranchTaken` are sampled only at the rising edge. Neither affects `Address` combinationally.
- A reset assertion mid-operation clears all state immediately, without waiting for a clock edge. The IDLE cycle repeats after reset release.

## Configuration

- `FETCH_MISALIGN_TRAP_EN` defined: a `BranchTaken` with `BranchTarget[1:0]`≠0 sets `Misaligned`=1 (sticky until reset), enters HALT with `Halted`=1, leaves PC unchanged, and writes `IfId_Valid`←0. A later `BranchTaken` does not exit this halt; only reset does.
- Not defined: `BranchTarget[1:0]` is forced to 0 on load, `Misaligned` is constant 0, and there is no trap logic.

## Test plan

- Reset → `Address`=0, `IfId_Valid`=0, `Halted`=0. First capture happens on the second edge after release, with `IfId_PC`=0.
- Free run over memory words 0..3 → `IfId_PC` is 0,4,8,C on consecutive edges, `IfId_Instruction` matches each word, `IfId_Valid`=1.
- `Stall`=1 for 3 cycles at PC=8 → `Address` holds 2 and the IF/ID outputs are unchanged. After release, capture resumes at PC=8 with no loss or duplication.
- `BranchTaken` with target 0x20 while PC=0x10 (also repeated with `Stall`=1) → one cycle with `IfId_Valid`=0, then `IfId_PC`=0x20, `Address`=8.
- Run from PC=0x7C → `Address` goes 31 then 0, and `IfId_PC` is 0x7C then 0x80. A word at the wrapped address holding 32'h0010_0073 → `Halted`=1, the EBREAK is delivered once, and `IfId_Valid` is 0 afterwards.
- With `FETCH_MISALIGN_TRAP_EN`, target 0x22 → `Misaligned`=1, `Halted`=1, PC unchanged. A further branch to 0x40 is ignored, and `rst_n` pulse clears both flags.
